ysyx_22050078_pipe_ctrl: RTL and testbench
==========================================

// Module: ysyx_22050078_pipe_ctrl
// PURPOSE
//  Central sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_LS, LS_WB) and the PC.
//  Generates per-stage write-enable / flush from three events: LSU memory wait, taken branch/jump, load-use hazard.
//  Owns the LS-stage memory valid/ready handshake FSM with a timeout watchdog. Sits beside the datapath in the core top.
// PARAMETERS
//  REG_ADDRW    5   register index width (match `REG_ADDRW)
//  MEM_TIMEOUT  15  WAIT cycles tolerated before sticky timeout error (>=1)
//  PERF_W       32  width of optional performance counters
// PORTS
//  clk           in   1          core clock, all state on rising edge
//  rst_n         in   1          asynchronous reset, active low
//  i_idu_rs1id   in   REG_ADDRW  ID-stage source 1 index
//  i_idu_rs1en   in   1          ID-stage reads rs1
//  i_idu_rs2id   in   REG_ADDRW  ID-stage source 2 index
//  i_idu_rs2en   in   1          ID-stage reads rs2
//  i_exu_rdid    in   REG_ADDRW  EX-stage destination index
//  i_exu_rdwen   in   1          EX-stage writes rd
//  i_exu_lden    in   1          EX-stage instruction is a load
//  i_exu_brjmp   in   1          EX-stage branch taken / jump (redirect)
//  i_lsu_memreq  in   1          LS-stage instruction accesses memory
//  i_mem_ready   in   1          memory accepts/completes request
//  o_mem_valid   out  1          request valid to memory
//  o_pc_wen      out  1          PC update enable
//  o_ifid_wen    out  1          IF_ID load enable
//  o_ifid_flush  out  1          IF_ID load bubble
//  o_idex_wen    out  1          ID_EX load enable
//  o_idex_flush  out  1          ID_EX load bubble
//  o_exls_wen    out  1          EX_LS load enable
//  o_lswb_wen    out  1          LS_WB load enable
//  o_lswb_flush  out  1          LS_WB load bubble
//  o_mem_timeout out  1          sticky: memory never answered
// BEHAVIOUR
//  - FSM {IDLE, WAIT, ERR}; reset -> IDLE, wait counter 0, o_mem_timeout 0. Only FSM/counter/error are registered; stage controls are combinational.
//  - flush asserted only with matching wen=1; a flushed register loads all-zero (nop, rdwen=0).
//  - IDLE: o_mem_valid = i_lsu_memreq. memreq&ready -> stays IDLE, no stall (zero-wait access). memreq&!ready -> WAIT, stall this cycle.
//  - WAIT: o_mem_valid=1 held; counter +1 per cycle. ready -> IDLE, counter cleared, stall released same cycle. counter==MEM_TIMEOUT-1 & !ready -> ERR.
//  - ERR: o_mem_valid=0, o_mem_timeout=1, all wen=0 (frozen) until rst_n.
//  - mem stall (IDLE&memreq&!ready, or WAIT&!ready): pc/ifid/idex/exls wen=0; lswb wen=1, flush=1 (bubble to WB).
//  - redirect (i_exu_brjmp, no mem stall): pc wen=1; ifid flush, idex flush; exls/lswb advance.
//  - load-use (i_exu_lden & i_exu_rdwen & rdid!=0 & ((rs1en&rs1id==rdid)|(rs2en&rs2id==rdid)), no stall/redirect): pc, ifid wen=0; idex flush; exls/lswb advance. Exactly one bubble per hazard.
//  - Priority: ERR > mem stall > redirect > load-use > normal (all wen=1, flush=0).
//  - Redirect during mem stall is held, not lost: EX frozen, brjmp re-evaluated on release.
//  - Reset mid-WAIT: immediately IDLE, o_mem_valid drops asynchronously.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: add outputs o_perf_stall [PERF_W], o_perf_flush [PERF_W]; stall +1 per mem-stall or load-use cycle, flush +1 per redirect cycle; wrap modulo 2^PERF_W; reset 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  defines.v: `PCTL_IDLE/`PCTL_WAIT/`PCTL_ERR 2-bit encodings, `REG_ADDRW, `CPU_WIDTH.
//  Sub-module ysyx_22050078_lsu_memwait: FSM + timeout counter + o_mem_valid/o_mem_timeout, exports mem_stall. Hazard/priority logic stays in top. State regs via stl_reg.
// TESTING
//  1 memreq=1, ready=1 same cycle -> valid=1, all wen=1, no bubble, state IDLE.
//  2 memreq=1, ready at 3rd cycle -> 2 stall cycles (pc/ifid/idex/exls wen=0, lswb flush=1), release cycle 3.
//  3 EX ld x5, ID add x6,x5,x1 -> one cycle pc/ifid wen=0, idex_flush=1; next cycle normal. rdid=0 -> no stall.
//  4 brjmp=1 with load-use present -> redirect only: ifid/idex flush, pc_wen=1.
//  5 MEM_TIMEOUT=4, ready never -> ERR after 4 WAIT cycles, timeout=1, all wen=0; rst_n low -> IDLE, timeout=0.
//  6 PIPE_CTRL_PERF_EN: scenario 2 then 3 then 4 -> o_perf_stall=3, o_perf_flush=1.

Source files
------------

// File: rtl/ysyx_22050078_pipe_ctrl_pkg.sv
// rtl/ysyx_22050078_pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencer
//
// Purpose: LS memory-wait FSM state encodings, core-wide widths and the bundled
//          per-stage control word with its canned values for each pipeline event.
// Ports:   none (package).
package ysyx_22050078_pipe_ctrl_pkg;

  localparam int REG_ADDRW = 5;
  localparam int CPU_WIDTH = 64;

  typedef enum logic [1:0] {
    PCTL_IDLE = 2'd0,
    PCTL_WAIT = 2'd1,
    PCTL_ERR  = 2'd2
  } pctl_state_e;

  // One control word for every pipeline register plus the PC.
  typedef struct packed {
    logic pc_wen;
    logic ifid_wen;
    logic ifid_flush;
    logic idex_wen;
    logic idex_flush;
    logic exls_wen;
    logic lswb_wen;
    logic lswb_flush;
  } stage_ctrl_t;

  // Everything advances.
  localparam stage_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  // Memory timed out: the whole pipe is frozen until reset.
  localparam stage_ctrl_t CTRL_FROZEN   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // LS waits on memory: IF..LS hold, WB receives a bubble.
  localparam stage_ctrl_t CTRL_MEMSTALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  // Taken branch/jump in EX: squash the two younger instructions.
  localparam stage_ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  // Load-use: hold IF/ID, inject one bubble into EX.
  localparam stage_ctrl_t CTRL_LOADUSE  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/ysyx_22050078_lsu_memwait.sv
// rtl/ysyx_22050078_lsu_memwait.sv - LS-stage memory valid/ready handshake FSM with timeout watchdog
//
// Purpose: drives o_mem_valid, tracks how long memory has kept LS waiting and
//          latches a sticky timeout error after MEM_TIMEOUT unanswered WAIT cycles.
// Ports:   clk, rst_n (async, active low)
//          i_lsu_memreq  LS instruction accesses memory
//          i_mem_ready   memory accepts/completes request
//          o_mem_valid   request valid to memory
//          o_mem_timeout sticky timeout error (state ERR)
//          o_mem_stall   LS must hold this cycle
module ysyx_22050078_lsu_memwait
  import ysyx_22050078_pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lsu_memreq,
  input  logic i_mem_ready,
  output logic o_mem_valid,
  output logic o_mem_timeout,
  output logic o_mem_stall
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  pctl_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PCTL_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    o_mem_valid   = 1'b0;
    o_mem_timeout = 1'b0;
    o_mem_stall   = 1'b0;
    case (state)
      PCTL_IDLE: begin
        o_mem_valid = i_lsu_memreq;
        // A zero-wait access completes here without ever entering WAIT.
        if (i_lsu_memreq && !i_mem_ready) begin
          o_mem_stall = 1'b1;
          state_nxt   = PCTL_WAIT;
          cnt_nxt     = '0;
        end
      end
      PCTL_WAIT: begin
        // Request stays up even if LS-side memreq wiggles: the bus owns it now.
        o_mem_valid = 1'b1;
        if (i_mem_ready) begin
          state_nxt = PCTL_IDLE;
          cnt_nxt   = '0;
        end else begin
          o_mem_stall = 1'b1;
          if (cnt == CNT_LAST) begin
            state_nxt = PCTL_ERR;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      PCTL_ERR: begin
        o_mem_timeout = 1'b1;
      end
      default: begin
        state_nxt = PCTL_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22050078_pipe_ctrl.sv
// rtl/ysyx_22050078_pipe_ctrl.sv - central write-enable/flush sequencer for the 5-stage pipeline
//
// Purpose: combines LSU memory wait, EX redirect and load-use hazard into PC and
//          pipeline-register load/bubble controls (priority: timeout error > mem
//          stall > redirect > load-use > normal).
// Ports:   clk, rst_n (async, active low)
//          i_idu_rs1id/rs1en, i_idu_rs2id/rs2en  ID-stage source operands
//          i_exu_rdid/rdwen/lden/brjmp           EX-stage destination, load, redirect
//          i_lsu_memreq, i_mem_ready, o_mem_valid memory handshake
//          o_pc_wen, o_*_wen, o_*_flush          stage controls (flush only with wen)
//          o_mem_timeout                          sticky memory timeout error
// Config:  PIPE_CTRL_PERF_EN adds o_perf_stall / o_perf_flush event counters.
module ysyx_22050078_pipe_ctrl
  import ysyx_22050078_pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDRW   = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int PERF_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_ADDRW-1:0] i_idu_rs1id,
  input  logic                 i_idu_rs1en,
  input  logic [REG_ADDRW-1:0] i_idu_rs2id,
  input  logic                 i_idu_rs2en,
  input  logic [REG_ADDRW-1:0] i_exu_rdid,
  input  logic                 i_exu_rdwen,
  input  logic                 i_exu_lden,
  input  logic                 i_exu_brjmp,
  input  logic                 i_lsu_memreq,
  input  logic                 i_mem_ready,
  output logic                 o_mem_valid,
  output logic                 o_pc_wen,
  output logic                 o_ifid_wen,
  output logic                 o_ifid_flush,
  output logic                 o_idex_wen,
  output logic                 o_idex_flush,
  output logic                 o_exls_wen,
  output logic                 o_lswb_wen,
  output logic                 o_lswb_flush,
`ifdef PIPE_CTRL_PERF_EN
  output logic [PERF_W-1:0]    o_perf_stall,
  output logic [PERF_W-1:0]    o_perf_flush,
`endif
  output logic                 o_mem_timeout
);

  // Degenerate widths/timeouts have no sensible hardware meaning.
  if (PERF_W < 1 || MEM_TIMEOUT < 1) begin : g_param_unsupported
  end

  logic        mem_stall;
  logic        load_use;
  stage_ctrl_t ctrl;

  ysyx_22050078_lsu_memwait #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_memwait (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_lsu_memreq  (i_lsu_memreq),
    .i_mem_ready   (i_mem_ready),
    .o_mem_valid   (o_mem_valid),
    .o_mem_timeout (o_mem_timeout),
    .o_mem_stall   (mem_stall)
  );

  // x0 is never a real producer, so a load into it cannot create a hazard.
  assign load_use = i_exu_lden && i_exu_rdwen && (i_exu_rdid != '0) &&
                    ((i_idu_rs1en && (i_idu_rs1id == i_exu_rdid)) ||
                     (i_idu_rs2en && (i_idu_rs2id == i_exu_rdid)));

  // A redirect seen during a mem stall is not lost: EX is frozen, so brjmp
  // is simply presented again on the release cycle.
  always_comb begin
    ctrl = CTRL_RUN;
    if (o_mem_timeout) begin
      ctrl = CTRL_FROZEN;
    end else if (mem_stall) begin
      ctrl = CTRL_MEMSTALL;
    end else if (i_exu_brjmp) begin
      ctrl = CTRL_REDIRECT;
    end else if (load_use) begin
      ctrl = CTRL_LOADUSE;
    end
  end

  assign o_pc_wen     = ctrl.pc_wen;
  assign o_ifid_wen   = ctrl.ifid_wen;
  assign o_ifid_flush = ctrl.ifid_flush;
  assign o_idex_wen   = ctrl.idex_wen;
  assign o_idex_flush = ctrl.idex_flush;
  assign o_exls_wen   = ctrl.exls_wen;
  assign o_lswb_wen   = ctrl.lswb_wen;
  assign o_lswb_flush = ctrl.lswb_flush;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = !o_mem_timeout && (mem_stall || (!i_exu_brjmp && load_use));
  assign flush_evt = !o_mem_timeout && !mem_stall && i_exu_brjmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_perf_stall <= '0;
      o_perf_flush <= '0;
    end else begin
      if (stall_evt) o_perf_stall <= o_perf_stall + 1'b1;
      if (flush_evt) o_perf_flush <= o_perf_flush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050078_pipe_ctrl.sv
// tb/tb_ysyx_22050078_pipe_ctrl.sv - self-checking bench for the pipeline sequencer
module tb_ysyx_22050078_pipe_ctrl;

  localparam int TO = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rs1id = '0, rs2id = '0, rdid = '0;
  logic          rs1en = 0, rs2en = 0, rdwen = 0, lden = 0, brjmp = 0;
  logic          memreq = 0, ready = 0;
  logic          mem_valid, pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush;
  logic          exls_wen, lswb_wen, lswb_flush, mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   perf_stall, perf_flush;
`endif

  always #5 clk = ~clk;

  ysyx_22050078_pipe_ctrl #(
    .REG_ADDRW   (AW),
    .MEM_TIMEOUT (TO),
    .PERF_W      (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_idu_rs1id   (rs1id),
    .i_idu_rs1en   (rs1en),
    .i_idu_rs2id   (rs2id),
    .i_idu_rs2en   (rs2en),
    .i_exu_rdid    (rdid),
    .i_exu_rdwen   (rdwen),
    .i_exu_lden    (lden),
    .i_exu_brjmp   (brjmp),
    .i_lsu_memreq  (memreq),
    .i_mem_ready   (ready),
    .o_mem_valid   (mem_valid),
    .o_pc_wen      (pc_wen),
    .o_ifid_wen    (ifid_wen),
    .o_ifid_flush  (ifid_flush),
    .o_idex_wen    (idex_wen),
    .o_idex_flush  (idex_flush),
    .o_exls_wen    (exls_wen),
    .o_lswb_wen    (lswb_wen),
    .o_lswb_flush  (lswb_flush),
`ifdef PIPE_CTRL_PERF_EN
    .o_perf_stall  (perf_stall),
    .o_perf_flush  (perf_flush),
`endif
    .o_mem_timeout (mem_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a memory access either is outstanding or not, the number
  // of unanswered WAIT cycles, and whether memory has been declared dead.
  bit          m_outstanding = 0;
  int          m_waited = 0;
  bit          m_dead = 0;
  logic [31:0] m_pstall = 0, m_pflush = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit mr, input bit rdy, input bit bj, input bit ld, input bit rw,
                        input int rd, input bit e1, input int r1, input bit e2, input int r2);
    memreq = mr; ready = rdy; brjmp = bj; lden = ld; rdwen = rw;
    rdid = AW'(rd); rs1en = e1; rs1id = AW'(r1); rs2en = e2; rs2id = AW'(r2);
  endtask

  // Called right after a negedge with inputs already driven; ends on the next negedge.
  task automatic step(input string tag);
    bit valid, stall, redir, lu, hazard;
    logic [8:0] exp, got;
    #1;
    valid  = m_dead ? 1'b0 : (m_outstanding ? 1'b1 : memreq);
    stall  = !m_dead && valid && !ready;
    hazard = lden && rdwen && (rdid != 0) &&
             ((rs1en && rs1id == rdid) || (rs2en && rs2id == rdid));
    redir  = !m_dead && !stall && brjmp;
    lu     = !m_dead && !stall && !brjmp && hazard;
    exp = {valid,
           !m_dead && !stall && !lu,   // pc
           !m_dead && !stall && !lu,   // ifid wen
           redir,                      // ifid flush
           !m_dead && !stall,          // idex wen
           redir || lu,                // idex flush
           !m_dead && !stall,          // exls wen
           !m_dead,                    // lswb wen
           stall};                     // lswb flush
    got = {mem_valid, pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush,
           exls_wen, lswb_wen, lswb_flush};
    check({tag, ".ctrl"}, 32'(got), 32'(exp));
    check({tag, ".timeout"}, 32'(mem_timeout), 32'(m_dead));
`ifdef PIPE_CTRL_PERF_EN
    check({tag, ".pstall"}, perf_stall, m_pstall);
    check({tag, ".pflush"}, perf_flush, m_pflush);
`endif
    @(posedge clk);
    if (stall || lu) m_pstall = m_pstall + 1;
    if (redir)       m_pflush = m_pflush + 1;
    if (!m_dead) begin
      if (m_outstanding) begin
        if (ready) begin
          m_outstanding = 0;
          m_waited = 0;
        end else begin
          m_waited++;
          if (m_waited == TO) m_dead = 1;
        end
      end else if (memreq && !ready) begin
        m_outstanding = 1;
        m_waited = 0;
      end
    end
    @(negedge clk);
  endtask

  // Reset lands mid-phase (asynchronously); valid must drop immediately.
  task automatic do_reset(input string tag);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, ".rst_valid"}, 32'(mem_valid), 32'd0);
    check({tag, ".rst_timeout"}, 32'(mem_timeout), 32'd0);
    m_outstanding = 0; m_waited = 0; m_dead = 0; m_pstall = 0; m_pflush = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset("init");

    // 1: zero-wait access
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step("s1_zero_wait");
    // 2: ready on the 3rd cycle -> two stall cycles then release
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("s2_stall1");
    step("s2_stall2");
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step("s2_release");
    // 3: ld x5 in EX, add x6,x5,x1 in ID -> one bubble, then EX holds a nop
    set_in(0, 0, 0, 1, 1, 5, 1, 5, 1, 1); step("s3_loaduse");
    set_in(0, 0, 0, 0, 0, 0, 1, 5, 1, 1); step("s3_after");
    set_in(0, 0, 0, 1, 1, 0, 1, 0, 0, 0); step("s3_x0");
    // 4: redirect wins over load-use
    set_in(0, 0, 1, 1, 1, 7, 0, 0, 1, 7); step("s4_redirect");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("s4_after");
`ifdef PIPE_CTRL_PERF_EN
    check("s6_perf_stall", perf_stall, 32'd3);
    check("s6_perf_flush", perf_flush, 32'd1);
`endif
    // redirect held across a mem stall, taken on release
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); step("hold_br_stall");
    set_in(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); step("hold_br_release");
    // 5: memory never answers
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step($sformatf("s5_to%0d", i));
    check("s5_sticky_timeout", 32'(mem_timeout), 32'd1);
    do_reset("s5_reset");
    // reset while WAIT is in progress
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("midwait_a");
    step("midwait_b");
    do_reset("midwait_reset");

    // Randomized traffic, reset periodically so timeouts do not end the run.
    for (int blk = 0; blk < 10; blk++) begin
      int rdy_bias = $urandom_range(1, 4);
      for (int c = 0; c < 40; c++) begin
        set_in($urandom_range(0, 1), $urandom_range(0, 4) < rdy_bias,
               $urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 3));
        step($sformatf("rnd%0d_%0d", blk, c));
      end
      do_reset($sformatf("rnd%0d_reset", blk));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
